// File: rtl/regfile_bypass.sv
// 32 x WIDTH general-purpose register file: two architectural read ports with
// optional same-cycle write forwarding, one unforwarded debug port, r0 hardwired zero.
module regfile_bypass #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  input  logic [4:0]       ctrl_readRegDbg,
  input  logic [WIDTH-1:0] data_writeReg,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic [WIDTH-1:0] data_readRegDbg,
  output logic [31:0]      reg_written
);

  logic [WIDTH-1:0] regs    [1:31];
  logic [WIDTH-1:0] reg_out [0:31];
  logic [31:0]      wr_onehot;
  logic [31:0]      written_q;
  logic             fwd_ok;

  // Bit 0 of the decode is forced low so r0 can never be written or flagged.
  always_comb begin
    wr_onehot    = '0;
    if (ctrl_writeEnable) wr_onehot = 32'd1 << ctrl_writeReg;
    wr_onehot[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      written_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_onehot[i]) begin
          regs[i]      <= data_writeReg;
          written_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    reg_out[0] = '0;
    for (int i = 1; i < 32; i++) reg_out[i] = regs[i];
  end

  // Forwarding only for a write that will actually land this edge.
  always_comb begin
    fwd_ok = BYPASS && ctrl_writeEnable && !reset && (ctrl_writeReg != 5'd0);
  end

  always_comb begin
    data_readRegA = reg_out[ctrl_readRegA];
    data_readRegB = reg_out[ctrl_readRegB];
    if (fwd_ok && (ctrl_readRegA == ctrl_writeReg)) data_readRegA = data_writeReg;
    if (fwd_ok && (ctrl_readRegB == ctrl_writeReg)) data_readRegB = data_writeReg;
  end

  always_comb begin
    data_readRegDbg = reg_out[ctrl_readRegDbg];
    reg_written     = {written_q[31:1], 1'b0};
  end

endmodule
